// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP over shared ALU, memory port and immgen.
// Latency: R/I/U/store 4 cycles, load 5, branch/JAL/JALR 3 (zero-wait memory); outputs are combinational from state.
// Backpressure: FETCH and MEM hold mem_req until mem_ready; MEM_TIMEOUT unacknowledged cycles -> TRAP.
// Optional macro MULTICYCLE_CTRL_PERF_EN adds the instret retired-instruction counter output.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal_inst,
`ifdef MULTICYCLE_CTRL_PERF_EN
    output logic [31:0] instret,
`endif
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;

    // Only the opcode field steers control; the rest of the IR feeds the datapath directly.
    logic [6:0] opcode;
    logic       unused_inst_bits;
    assign opcode           = inst[6:0];
    assign unused_inst_bits = ^inst[31:7];

    logic is_load, is_store, is_alui, is_alur, is_branch, is_jal, is_jalr, is_lui, is_auipc, is_legal;
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_alui   = (opcode == 7'b0010011);
    assign is_alur   = (opcode == 7'b0110011);
    assign is_branch = (opcode == 7'b1100011);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_lui    = (opcode == 7'b0110111);
    assign is_auipc  = (opcode == 7'b0010111);
    assign is_legal  = is_load | is_store | is_alui | is_alur | is_branch |
                       is_jal | is_jalr | is_lui | is_auipc;

    // Immediate format for the latched opcode; 7 means no immediate (R-type or illegal).
    logic [2:0] imm_dec;
    always_comb begin
        imm_dec = 3'd7;
        if (is_load || is_alui || is_jalr) imm_dec = 3'd0;
        else if (is_store)                 imm_dec = 3'd1;
        else if (is_branch)                imm_dec = 3'd2;
        else if (is_lui || is_auipc)       imm_dec = 3'd3;
        else if (is_jal)                   imm_dec = 3'd4;
    end

    // State, wait counter and sticky trap flag; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and datapath control decode from current state and opcode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        imm_sel   = 3'd7;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    // Latch IR and advance PC by 4 through the shared ALU.
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd2;
                    state_d   = S_DECODE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                imm_sel = imm_dec;
                state_d = is_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                imm_sel = imm_dec;
                if (is_alur) begin
                    alu_op  = 2'd1;
                    state_d = S_WB;
                end else if (is_alui) begin
                    alu_src_b = 2'd1;
                    alu_op    = 2'd2;
                    state_d   = S_WB;
                end else if (is_load || is_store) begin
                    alu_src_b = 2'd1;
                    state_d   = S_MEM;
                end else if (is_branch) begin
                    // old_pc + B-imm is the target; comparator decides whether it is taken.
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    pc_write  = br_taken;
                    state_d   = S_FETCH;
                end else if (is_jal) begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                    state_d   = S_FETCH;
                end else if (is_jalr) begin
                    alu_src_b = 2'd1;
                    pc_src    = 1'b1;
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                    state_d   = S_FETCH;
                end else if (is_lui) begin
                    alu_src_a = 2'd3;
                    alu_src_b = 2'd1;
                    state_d   = S_WB;
                end else if (is_auipc) begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                    state_d   = S_WB;
                end else begin
                    // Unreachable: DECODE already filtered illegal opcodes.
                    state_d = S_TRAP;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                if (mem_ready) begin
                    state_d = is_store ? S_FETCH : S_WB;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = is_load ? 2'd1 : 2'd0;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Any entry into TRAP (illegal opcode or memory timeout) raises the sticky flag.
        if (state_d == S_TRAP) illegal_d = 1'b1;
    end

    assign illegal_inst = illegal_q;
    assign state_o      = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic        retire;
    logic [31:0] instret_q;
    assign retire = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) &&
                    (state_d == S_FETCH);

    // Retired-instruction counter; bumps on the return to FETCH and wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n)      instret_q <= '0;
        else if (retire) instret_q <= instret_q + 32'd1;
    end
    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors go into a scoreboard queue,
// a negedge monitor pops one entry per cycle and compares it with the DUT outputs.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = 32'h0;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write, illegal_inst;
    logic [2:0]  imm_sel, state_o;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, wb_sel;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instret;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .TMO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready), .br_taken(br_taken),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
        .illegal_inst(illegal_inst),
`ifdef MULTICYCLE_CTRL_PERF_EN
        .instret(instret),
`endif
        .state_o(state_o)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, asel, irw, pcw, pcs;
        logic [2:0] imm;
        logic [1:0] sa, sb, op;
        logic       rw;
        logic [1:0] wb;
        logic       ill;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
        bit    ill_dc;
    } item_t;

    item_t sbq[$];
    int    checks = 0;
    int    errors = 0;

    function automatic obs_t mk(int st, int req, int we, int asel, int irw, int pcw, int pcs,
                                int imm, int sa, int sb, int op, int rw, int wb, int ill);
        obs_t o;
        o.st = 3'(st); o.req = 1'(req); o.we = 1'(we); o.asel = 1'(asel);
        o.irw = 1'(irw); o.pcw = 1'(pcw); o.pcs = 1'(pcs); o.imm = 3'(imm);
        o.sa = 2'(sa); o.sb = 2'(sb); o.op = 2'(op); o.rw = 1'(rw); o.wb = 2'(wb); o.ill = 1'(ill);
        return o;
    endfunction

    function automatic obs_t f_rdy();  return mk(0,1,0,0,1,1,0,7,1,2,0,0,0,0); endfunction
    function automatic obs_t f_wait(); return mk(0,1,0,0,0,0,0,7,0,0,0,0,0,0); endfunction
    function automatic obs_t dec(int imm); return mk(1,0,0,0,0,0,0,imm,0,0,0,0,0,0); endfunction
    function automatic obs_t ex(int imm, int sa, int sb, int op, int pcw, int pcs, int rw, int wb);
        return mk(2,0,0,0,0,pcw,pcs,imm,sa,sb,op,rw,wb,0);
    endfunction
    function automatic obs_t memx(int we); return mk(3,1,we,1,0,0,0,7,0,0,0,0,0,0); endfunction
    function automatic obs_t wbx(int wb);  return mk(4,0,0,0,0,0,0,7,0,0,0,1,wb,0); endfunction
    function automatic obs_t trp();        return mk(5,0,0,0,0,0,0,7,0,0,0,0,0,1); endfunction

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic cyc(input logic mr, input logic bt, input obs_t e, input string tag, input bit idc);
        item_t it;
        it.v = e; it.tag = tag; it.ill_dc = idc;
        mem_ready = mr;
        br_taken  = bt;
        sbq.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic c(input logic mr, input logic bt, input obs_t e, input string tag);
        cyc(mr, bt, e, tag, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0; br_taken = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: one expected entry per active cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            item_t it;
            obs_t  a, x;
            it = sbq.pop_front();
            a.st = state_o; a.req = mem_req; a.we = mem_we; a.asel = addr_sel; a.irw = ir_write;
            a.pcw = pc_write; a.pcs = pc_src; a.imm = imm_sel; a.sa = alu_src_a; a.sb = alu_src_b;
            a.op = alu_op; a.rw = reg_write; a.wb = wb_sel; a.ill = illegal_inst;
            x = it.v;
            if (it.ill_dc) x.ill = a.ill;
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                         it.tag, a, a.st, x, x.st);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD x3,x1,x2 with mem_ready high every cycle (ignored outside FETCH/MEM)
        inst = 32'h002081B3;
        c(1,0,f_rdy(),"add_fetch_reset_state"); c(1,0,dec(7),"add_dec");
        c(1,0,ex(7,0,0,1,0,0,0,0),"add_exec"); c(1,0,wbx(0),"add_wb");
        // SW x2,8(x1)
        inst = 32'h0020A423;
        c(1,0,f_rdy(),"sw_fetch"); c(0,0,dec(1),"sw_dec");
        c(0,0,ex(1,0,1,0,0,0,0,0),"sw_exec"); c(1,0,memx(1),"sw_mem");
        // JAL x1,8
        inst = 32'h008000EF;
        c(1,0,f_rdy(),"jal_fetch"); c(0,0,dec(4),"jal_dec");
        c(0,0,ex(4,2,1,0,1,0,1,2),"jal_exec");
`ifdef MULTICYCLE_CTRL_PERF_EN
        checks++;
        if (instret !== 32'd3) begin
            errors++;
            $display("FAIL instret_after_3: got %0d expected 3", instret);
        end
`endif
        // LW x5,8(x1) with three wait cycles in MEM
        inst = 32'h0080A283;
        c(1,0,f_rdy(),"lw_fetch"); c(0,0,dec(0),"lw_dec");
        c(0,0,ex(0,0,1,0,0,0,0,0),"lw_exec");
        for (int i = 0; i < 3; i++) c(0,0,memx(0),"lw_mem_wait");
        c(1,0,memx(0),"lw_mem_ack"); c(0,0,wbx(1),"lw_wb");
        // BEQ not taken, then taken
        inst = 32'h00208463;
        c(1,0,f_rdy(),"beq0_fetch"); c(0,0,dec(2),"beq0_dec");
        c(0,0,ex(2,2,1,0,0,0,0,0),"beq0_exec_not_taken");
        c(1,1,f_rdy(),"beq1_fetch"); c(0,1,dec(2),"beq1_dec");
        c(0,1,ex(2,2,1,0,1,0,0,0),"beq1_exec_taken");
        // JALR x1,0(x1)
        inst = 32'h000080E7;
        c(1,0,f_rdy(),"jalr_fetch"); c(0,0,dec(0),"jalr_dec");
        c(0,0,ex(0,0,1,0,1,1,1,2),"jalr_exec");
        // LUI x5,0x12345
        inst = 32'h123452B7;
        c(1,0,f_rdy(),"lui_fetch"); c(0,0,dec(3),"lui_dec");
        c(0,0,ex(3,3,1,0,0,0,0,0),"lui_exec"); c(0,0,wbx(0),"lui_wb");
        // ADDI x1,x1,5
        inst = 32'h00508093;
        c(1,0,f_rdy(),"addi_fetch"); c(0,0,dec(0),"addi_dec");
        c(0,0,ex(0,0,1,2,0,0,0,0),"addi_exec"); c(0,0,wbx(0),"addi_wb");
        // AUIPC x5,1
        inst = 32'h00001297;
        c(1,0,f_rdy(),"auipc_fetch"); c(0,0,dec(3),"auipc_dec");
        c(0,0,ex(3,2,1,0,0,0,0,0),"auipc_exec"); c(0,0,wbx(0),"auipc_wb");

        // Reset mid-FETCH clears the retire counter
        c(0,0,f_wait(),"fetch_wait_pre_reset");
        do_reset();
`ifdef MULTICYCLE_CTRL_PERF_EN
        checks++;
        if (instret !== 32'd0) begin
            errors++;
            $display("FAIL instret_reset: got %0d expected 0", instret);
        end
`endif
        // Reset mid-MEM after two wait cycles, then a full FETCH timeout from a cleared counter
        inst = 32'h0080A283;
        c(1,0,f_rdy(),"lw2_fetch"); c(0,0,dec(0),"lw2_dec");
        c(0,0,ex(0,0,1,0,0,0,0,0),"lw2_exec");
        c(0,0,memx(0),"lw2_mem_wait"); c(0,0,memx(0),"lw2_mem_wait");
        do_reset();
        for (int i = 0; i < 16; i++) c(0,0,f_wait(),"timeout_fetch_req");
        c(0,0,trp(),"timeout_trap_entry"); c(1,0,trp(),"timeout_trap_hold");

        // Illegal opcode: DECODE -> TRAP, flag held, cleared by reset
        do_reset();
        inst = 32'h0000007F;
        c(1,0,f_rdy(),"ill_fetch");
        cyc(1,0,dec(7),"ill_dec",1'b1);
        for (int i = 0; i < 20; i++) c(1,0,trp(),"ill_trap_sticky");
        do_reset();
        c(0,0,f_wait(),"ill_after_reset");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
